fifo_rr_drain: RTL and testbench

- Round-robin read scheduler that drains N_CH non-showahead FIFOs into a single valid/ready output stream.
- Sits downstream of a bank of our fifo instances (SHOWAHEAD=0) and owns all their read-request lines.
- Hides the one-cycle FIFO read latency with a 2-entry output buffer, and bounds per-channel burst length for fairness.

---
 rtl/fifo_rr_drain.sv | 152 +++++++++++++++
 tb/tb_fifo_rr_drain.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N_CH non-showahead FIFOs into one valid/ready stream.
// A 2-entry output buffer absorbs the one-cycle FIFO read latency.
module fifo_rr_drain #(
  parameter int N_CH   = 4,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [N_CH-1:0]          ch_empty_i,
  input  logic [N_CH*DWIDTH-1:0]   ch_q_i,
  output logic [N_CH-1:0]          ch_rd_req_o,
  output logic [DWIDTH-1:0]        data_o,
  output logic [$clog2(N_CH)-1:0]  chan_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o
);

  localparam int CW = $clog2(N_CH);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_last, w_last_nxt;
  logic [CW-1:0]       r_cur, w_cur_nxt;
  logic [CW-1:0]       r_pend_ch;
  logic [BW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                r_pend;
  logic [1:0]          r_occ;
  logic [DWIDTH-1:0]   r_bd [2];
  logic [CW-1:0]       r_bc [2];

  logic                w_pop, w_issue_ok, w_issue, w_any;
  logic [CW-1:0]       w_pick;
  logic [DWIDTH-1:0]   w_cap_d;
  int unsigned         w_idx;

  assign w_pop      = (r_occ != 2'd0) && ready_i;
  // Counts the word in flight so a capture always finds a free slot.
  assign w_issue_ok = (({1'b0, r_occ} + {2'b00, r_pend}) - {2'b00, w_pop}) < 3'd2;
  assign w_issue    = (r_state == GRANT) && w_issue_ok && !ch_empty_i[r_cur];
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_cap_d    = ch_q_i[int'(r_pend_ch)*DWIDTH +: DWIDTH];

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      w_idx = (int'(r_last) + i) % N_CH;
      if (!w_any && !ch_empty_i[w_idx]) begin
        w_any  = 1'b1;
        w_pick = CW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state   <= IDLE;
      r_last    <= CW'(N_CH - 1);
      r_cur     <= '0;
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_pend_ch <= '0;
      r_occ     <= 2'd0;
      r_bd[0]   <= '0;
      r_bd[1]   <= '0;
      r_bc[0]   <= '0;
      r_bc[1]   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_issue;
      if (w_issue) r_pend_ch <= r_cur;
      case ({r_pend, w_pop})
        2'b10: begin
          r_bd[r_occ[0]] <= w_cap_d;
          r_bc[r_occ[0]] <= r_pend_ch;
          r_occ          <= r_occ + 2'd1;
        end
        2'b01: begin
          r_bd[0] <= r_bd[1];
          r_bc[0] <= r_bc[1];
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_bd[0] <= w_cap_d;
            r_bc[0] <= r_pend_ch;
          end else begin
            r_bd[0] <= r_bd[1];
            r_bc[0] <= r_bc[1];
            r_bd[1] <= w_cap_d;
            r_bc[1] <= r_pend_ch;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_cur_nxt   = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_issue) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == BW'(BURST)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_cur;
          end
        end else if (w_issue_ok && ch_empty_i[r_cur]) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_cur;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ch_rd_req_o = '0;
    if (w_issue) ch_rd_req_o[r_cur] = 1'b1;
    valid_o = (r_occ != 2'd0);
    data_o  = r_bd[0];
    chan_o  = r_bc[0];
    busy_o  = (r_state == GRANT) || r_pend || (r_occ != 2'd0);
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (srst_i)
    !(r_pend && !w_pop && (r_occ == 2'd2)));
  a_no_empty_read: assert property (@(posedge clk_i) disable iff (srst_i)
    ((ch_rd_req_o & ch_empty_i) == '0));
  a_onehot_req: assert property (@(posedge clk_i) disable iff (srst_i)
    $onehot0(ch_rd_req_o));

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain with behavioural non-showahead FIFO models.
module tb_fifo_rr_drain;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [3:0]  ch_empty;
  logic [31:0] ch_q;
  logic [3:0]  ch_rd_req;
  logic [7:0]  data;
  logic [1:0]  chan;
  logic        valid;
  logic        ready = 1'b0;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_rr_drain #(.N_CH(4), .DWIDTH(8), .BURST(4)) dut (
    .clk_i(clk), .srst_i(srst), .ch_empty_i(ch_empty), .ch_q_i(ch_q),
    .ch_rd_req_o(ch_rd_req), .data_o(data), .chan_o(chan), .valid_o(valid),
    .ready_i(ready), .busy_o(busy)
  );

  // FIFO models: q updates one edge after a read request.
  logic [7:0] fmem [4][16];
  int         wp [4];
  int         rp [4];
  logic [7:0] fq [4];

  always_comb begin
    ch_empty = '1;
    ch_q     = '0;
    for (int k = 0; k < 4; k++) begin
      ch_empty[k]     = (wp[k] == rp[k]);
      ch_q[k*8 +: 8]  = fq[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ch_rd_req[k] && (wp[k] != rp[k])) begin
        fq[k] <= fmem[k][rp[k] % 16];
        rp[k] <= rp[k] + 1;
      end
    end
  end

  // Monitor: scoreboard of accepted words plus protocol counters.
  logic [7:0] sb_d [256];
  logic [1:0] sb_c [256];
  int         sb_n = 0;
  int         rdcnt [4];
  int         viol = 0;
  int         onehot_err = 0;
  int         stab_err = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_d;
  logic [1:0] prev_c;

  always @(negedge clk) begin
    if (srst) begin
      prev_hold <= 1'b0;
    end else begin
      if (valid && ready) begin
        sb_d[sb_n] <= data;
        sb_c[sb_n] <= chan;
        sb_n       <= sb_n + 1;
      end
      if (prev_hold && (!valid || data !== prev_d || chan !== prev_c))
        stab_err <= stab_err + 1;
      prev_hold <= valid && !ready;
      prev_d    <= data;
      prev_c    <= chan;
      if ((ch_rd_req & ch_empty) != 4'h0) viol <= viol + 1;
      if (!$onehot0(ch_rd_req)) onehot_err <= onehot_err + 1;
      for (int k = 0; k < 4; k++) rdcnt[k] <= rdcnt[k] + int'(ch_rd_req[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    fmem[ch][wp[ch] % 16] = d;
    wp[ch] = wp[ch] + 1;
  endtask

  task automatic do_reset();
    tick();
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && ch_empty == 4'hF) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    srst  = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
    n_chk++; if (data !== 8'h00) $display("FAIL reset_data got %h want 00", data); else n_pass++;
    n_chk++; if (chan !== 2'd0) $display("FAIL reset_chan got %0d want 0", chan); else n_pass++;
    n_chk++; if (ch_rd_req !== 4'h0) $display("FAIL reset_rdreq got %b want 0000", ch_rd_req); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    srst = 1'b0;
    tick();
  endtask

  task automatic test_single_channel();
    int base;
    bit to;
    logic [15:0] prq, pv, pb;
    logic [7:0] ed [3];
    ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
    do_reset();
    ready = 1'b1;
    base = sb_n;
    push(1, 8'h11); push(1, 8'h22); push(1, 8'h33);
    prq = '0; pv = '0; pb = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      prq[c] = ch_rd_req[1];
      pv[c]  = valid;
      pb[c]  = busy;
    end
    tick();
    n_chk++; if (prq !== 16'h000E) $display("FAIL single_rdreq_pattern got %h want 000e", prq); else n_pass++;
    n_chk++; if (pv !== 16'h0038) $display("FAIL single_valid_pattern got %h want 0038", pv); else n_pass++;
    n_chk++; if (pb !== 16'h003E) $display("FAIL single_busy_pattern got %h want 003e", pb); else n_pass++;
    n_chk++; if (sb_n - base !== 3) $display("FAIL single_count got %0d want 3", sb_n - base); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (sb_d[base+i] !== ed[i] || sb_c[base+i] !== 2'd1)
        $display("FAIL single_word%0d got %h/ch%0d want %h/ch1", i, sb_d[base+i], sb_c[base+i], ed[i]);
      else n_pass++;
    end
    // last=1 now, so ch2 must win over ch0.
    base = sb_n;
    push(0, 8'hA0); push(2, 8'hC0);
    wait_drain(200, to);
    n_chk++; if (to) $display("FAIL after_last1_timeout busy=%b empty=%b want drained", busy, ch_empty); else n_pass++;
    n_chk++; if (sb_n - base !== 2) $display("FAIL after_last1_count got %0d want 2", sb_n - base); else n_pass++;
    n_chk++;
    if (sb_c[base] !== 2'd2 || sb_d[base] !== 8'hC0 || sb_c[base+1] !== 2'd0 || sb_d[base+1] !== 8'hA0)
      $display("FAIL after_last1_order got %h/ch%0d,%h/ch%0d want c0/ch2,a0/ch0",
               sb_d[base], sb_c[base], sb_d[base+1], sb_c[base+1]);
    else n_pass++;
  endtask

  task automatic test_all_channels();
    int base, ne;
    bit to;
    logic [7:0] exd [32];
    logic [1:0] exc [32];
    do_reset();
    ready = 1'b1;
    base = sb_n;
    for (int ch = 0; ch < 4; ch++)
      for (int w = 0; w < 6; w++) push(ch, 8'(ch*16 + w));
    ne = 0;
    for (int ch = 0; ch < 4; ch++)
      for (int w = 0; w < 4; w++) begin exd[ne] = 8'(ch*16 + w); exc[ne] = 2'(ch); ne++; end
    for (int ch = 0; ch < 4; ch++)
      for (int w = 4; w < 6; w++) begin exd[ne] = 8'(ch*16 + w); exc[ne] = 2'(ch); ne++; end
    wait_drain(400, to);
    n_chk++; if (to) $display("FAIL all_timeout busy=%b empty=%b want drained", busy, ch_empty); else n_pass++;
    n_chk++; if (sb_n - base !== 24) $display("FAIL all_count got %0d want 24", sb_n - base); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      n_chk++;
      if (sb_d[base+i] !== exd[i] || sb_c[base+i] !== exc[i])
        $display("FAIL all_word%0d got %h/ch%0d want %h/ch%0d", i, sb_d[base+i], sb_c[base+i], exd[i], exc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int base, s0;
    bit to;
    logic [3:0] rpat;
    rpat = 4'b1001;
    do_reset();
    base = sb_n;
    s0 = stab_err;
    for (int w = 0; w < 4; w++) push(0, 8'(8'h40 + w));
    for (int c = 0; c < 40; c++) begin
      ready = rpat[c % 4];
      tick();
    end
    ready = 1'b1;
    wait_drain(200, to);
    n_chk++; if (to) $display("FAIL bp_timeout busy=%b empty=%b want drained", busy, ch_empty); else n_pass++;
    n_chk++; if (sb_n - base !== 4) $display("FAIL bp_count got %0d want 4", sb_n - base); else n_pass++;
    n_chk++; if (stab_err - s0 !== 0) $display("FAIL bp_stability got %0d errors want 0", stab_err - s0); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (sb_d[base+i] !== 8'(8'h40 + i) || sb_c[base+i] !== 2'd0)
        $display("FAIL bp_word%0d got %h/ch%0d want %h/ch0", i, sb_d[base+i], sb_c[base+i], 8'(8'h40 + i));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int base;
    bit to;
    logic [7:0] exd [6];
    logic [1:0] exc [6];
    exd[0] = 8'h01; exd[1] = 8'h02; exd[2] = 8'h03; exd[3] = 8'h04; exd[4] = 8'h21; exd[5] = 8'h05;
    exc[0] = 2'd0;  exc[1] = 2'd0;  exc[2] = 2'd0;  exc[3] = 2'd0;  exc[4] = 2'd2;  exc[5] = 2'd0;
    do_reset();
    ready = 1'b1;
    push(1, 8'h1E);
    wait_drain(200, to);
    push(3, 8'h3F);
    wait_drain(200, to);
    base = sb_n;
    for (int w = 1; w <= 5; w++) push(0, 8'(w));
    push(2, 8'h21);
    wait_drain(200, to);
    n_chk++; if (to) $display("FAIL wrap_timeout busy=%b empty=%b want drained", busy, ch_empty); else n_pass++;
    n_chk++; if (sb_n - base !== 6) $display("FAIL wrap_count got %0d want 6", sb_n - base); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (sb_d[base+i] !== exd[i] || sb_c[base+i] !== exc[i])
        $display("FAIL wrap_word%0d got %h/ch%0d want %h/ch%0d", i, sb_d[base+i], sb_c[base+i], exd[i], exc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_run_dry();
    int base, r2, r3;
    bit to;
    do_reset();
    ready = 1'b1;
    base = sb_n;
    r2 = rdcnt[2];
    r3 = rdcnt[3];
    push(2, 8'h2A); push(2, 8'h2B); push(3, 8'h3A);
    wait_drain(200, to);
    n_chk++; if (to) $display("FAIL dry_timeout busy=%b empty=%b want drained", busy, ch_empty); else n_pass++;
    n_chk++; if (rdcnt[2] - r2 !== 2) $display("FAIL dry_reads_ch2 got %0d want 2", rdcnt[2] - r2); else n_pass++;
    n_chk++; if (rdcnt[3] - r3 !== 1) $display("FAIL dry_reads_ch3 got %0d want 1", rdcnt[3] - r3); else n_pass++;
    n_chk++;
    if (sb_n - base !== 3 || sb_d[base] !== 8'h2A || sb_c[base] !== 2'd2 || sb_d[base+1] !== 8'h2B ||
        sb_c[base+1] !== 2'd2 || sb_d[base+2] !== 8'h3A || sb_c[base+2] !== 2'd3)
      $display("FAIL dry_order got n=%0d %h/ch%0d,%h/ch%0d,%h/ch%0d want 3 2a/ch2,2b/ch2,3a/ch3", sb_n - base,
               sb_d[base], sb_c[base], sb_d[base+1], sb_c[base+1], sb_d[base+2], sb_c[base+2]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int base;
    bit to;
    do_reset();
    ready = 1'b0;
    push(1, 8'h51); push(1, 8'h52); push(1, 8'h53); push(1, 8'h54);
    repeat (6) tick();
    ready = 1'b1;
    #1;
    n_chk++; if (valid !== 1'b1) $display("FAIL midrst_pre_valid got %b want 1", valid); else n_pass++;
    n_chk++; if (ch_rd_req !== 4'b0010) $display("FAIL midrst_pre_rdreq got %b want 0010", ch_rd_req); else n_pass++;
    #1;
    srst = 1'b1;
    #1;
    n_chk++; if (valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", valid); else n_pass++;
    n_chk++; if (ch_rd_req !== 4'h0) $display("FAIL midrst_rdreq got %b want 0000", ch_rd_req); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    push(0, 8'h0A);
    base = sb_n;
    tick();
    tick();
    srst = 1'b0;
    wait_drain(200, to);
    n_chk++; if (to) $display("FAIL midrst_timeout busy=%b empty=%b want drained", busy, ch_empty); else n_pass++;
    n_chk++;
    if (sb_n - base !== 3 || sb_d[base] !== 8'h0A || sb_c[base] !== 2'd0 || sb_d[base+1] !== 8'h53 ||
        sb_c[base+1] !== 2'd1 || sb_d[base+2] !== 8'h54 || sb_c[base+2] !== 2'd1)
      $display("FAIL midrst_order got n=%0d %h/ch%0d,%h/ch%0d,%h/ch%0d want 3 0a/ch0,53/ch1,54/ch1", sb_n - base,
               sb_d[base], sb_c[base], sb_d[base+1], sb_c[base+1], sb_d[base+2], sb_c[base+2]);
    else n_pass++;
  endtask

  task automatic test_protocol();
    n_chk++; if (viol !== 0) $display("FAIL proto_read_empty got %0d want 0", viol); else n_pass++;
    n_chk++; if (onehot_err !== 0) $display("FAIL proto_onehot got %0d want 0", onehot_err); else n_pass++;
    n_chk++; if (stab_err !== 0) $display("FAIL proto_stability got %0d want 0", stab_err); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      wp[k] = 0;
      rdcnt[k] = 0;
    end
    test_reset();
    test_single_channel();
    test_all_channels();
    test_backpressure();
    test_wrap();
    test_run_dry();
    test_reset_mid_burst();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    for (int k = 0; k < 4; k++) rp[k] = 0;
  end

endmodule
